// File: rtl/axi_tx_arbiter.sv
// axi_tx_arbiter: round-robin, packet-locked arbiter sharing one AXI-stream tx channel
// between NUM_REQ requesters through a one-entry registered output stage.
// Optional build macro AXI_ARB_PRIO_EN: requester 0 gets strict priority at arbitration,
// the remaining requesters stay round-robin among themselves.
module axi_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned t_data_bit   = 128,
    parameter int unsigned t_user_width = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*t_data_bit-1:0]     req_data,
    input  logic [NUM_REQ*t_user_width-1:0]   req_user,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic                              t_valid,
    input  logic                              t_ready,
    output logic [t_data_bit-1:0]             t_data,
    output logic [t_user_width-1:0]           t_user,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                    state_q, state_d;
    logic [IdW-1:0]            grant_q, grant_d;
    logic [IdW-1:0]            rr_ptr_q, rr_ptr_d;
    logic                      t_valid_q;
    logic [t_data_bit-1:0]     t_data_q;
    logic [t_user_width-1:0]   t_user_q;

    logic [IdW-1:0]            pick;
    logic                      pick_found;
    logic [IdW-1:0]            scan_idx;
    logic [IdW-1:0]            grant_inc;
    logic                      stage_free;
    logic                      load;

    // Output stage can take a beat when empty or draining this cycle.
    assign stage_free = !t_valid_q || t_ready;
    assign load       = (state_q == StBusy) && req_valid[grant_q] && stage_free;
    assign grant_inc  = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + IdW'(1);

    // Arbitration: first valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
`ifdef AXI_ARB_PRIO_EN
        if (req_valid[0]) begin
            pick       = '0;
            pick_found = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
`ifdef AXI_ARB_PRIO_EN
            // Requester 0 is handled above; the rest rotate among themselves.
            if (!pick_found && req_valid[scan_idx] && (scan_idx != '0)) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
`else
            if (!pick_found && req_valid[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
`endif
        end
    end

    // Only the owner sees ready; t_ready reaches req_ready combinationally.
    always_comb begin
        req_ready = '0;
        if (state_q == StBusy) begin
            req_ready[grant_q] = stage_free;
        end
    end

    // Next-state logic: grant on entry to BUSY, release on accepted last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (load && req_last[grant_q]) begin
                    state_d = StIdle;
`ifdef AXI_ARB_PRIO_EN
                    if (grant_q != '0) begin
                        rr_ptr_d = grant_inc;
                    end
`else
                    rr_ptr_d = grant_inc;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Registered output stage: load wins over drain so back-to-back beats stay valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_valid_q <= 1'b0;
            t_data_q  <= '0;
            t_user_q  <= '0;
        end else if (load) begin
            t_valid_q <= 1'b1;
            t_data_q  <= req_data[32'(grant_q) * t_data_bit +: t_data_bit];
            t_user_q  <= req_user[32'(grant_q) * t_user_width +: t_user_width];
        end else if (t_valid_q && t_ready) begin
            t_valid_q <= 1'b0;
        end
    end

    assign t_valid  = t_valid_q;
    assign t_data   = t_data_q;
    assign t_user   = t_user_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == StBusy);

endmodule
